panel_timing_gen: RTL and testbench
===================================

// Module: panel_timing_gen
// PURPOSE
//  Raster timing generator for the LVDS panel pattern path. Free-runs H/V counters
//  and emits registered hsync, vsync, data-enable, pixel x/y and a frame-start pulse.
//  Its vsync drives the frame-based seconds counter. Its de/x/y drive the pattern
//  generators that feed the LVDS serializer.
// PARAMETERS
//  H_ACTIVE  1920  active pixels per line
//  H_FP      88    horizontal front porch, in clocks
//  H_SYNC    44    hsync pulse width, in clocks
//  H_BP      148   horizontal back porch, in clocks (H_TOTAL = sum of the four = 2200)
//  V_ACTIVE  1080  active lines per frame
//  V_FP      4     vertical front porch, in lines
//  V_SYNC    5     vsync pulse width, in lines
//  V_BP      36    vertical back porch, in lines (V_TOTAL = 1125)
//  H_POL     1     hsync active level (1 = active-high)
//  V_POL     1     vsync active level (1 = active-high)
//  CNT_W     12    width of counters and x/y; must satisfy H_TOTAL, V_TOTAL <= 2^CNT_W
// PORTS
//  iclk          in   1      pixel clock; single clock domain
//  irst          in   1      synchronous reset, active-low
//  ien           in   1      run enable; low = hold raster at origin
//  ohsync        out  1      horizontal sync, polarity per H_POL
//  ovsync        out  1      vertical sync, polarity per V_POL
//  ode           out  1      data enable, high during active pixels
//  ox            out  CNT_W  active pixel column, 0..H_ACTIVE-1; 0 when ode=0
//  oy            out  CNT_W  active line, 0..V_ACTIVE-1; 0 when ode=0
//  oframe_start  out  1      1-clock pulse on the first active pixel of each frame
// BEHAVIOUR
//  - Internal counters: h_cnt runs 0..H_TOTAL-1; v_cnt runs 0..V_TOTAL-1.
//    - h_cnt increments every clock while ien=1.
//    - At h_cnt = H_TOTAL-1: h_cnt wraps to 0 and v_cnt increments.
//    - v_cnt wraps to 0 after V_TOTAL-1 (on the same clock h_cnt wraps).
//  - Line order: active, front porch, sync, back porch. Frame order is the same, in lines.
//  - Decode, from the counter values on clock n:
//    - hs_act  = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//    - vs_act  = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//    - de      = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
//    - fs      = (h_cnt == 0) && (v_cnt == 0)
//  - Output registers, loaded on clock n+1 from the clock-n decode (1-clock latency):
//    - ohsync = hs_act ? H_POL : ~H_POL
//    - ovsync = vs_act ? V_POL : ~V_POL
//    - ode = de; oframe_start = fs
//    - ox = de ? h_cnt : 0; oy = de ? v_cnt : 0
//  - vsync edges are aligned to line start: both edges occur on the output clock
//    after h_cnt = 0. Pulse width is exactly V_SYNC*H_TOTAL clocks.
//  - Exactly one rising edge of the active vsync level per frame.
//  - Reset (irst=0, sampled on iclk) has priority over ien:
//    - h_cnt = v_cnt = 0
//    - ohsync = ~H_POL, ovsync = ~V_POL
//    - ode = 0, ox = 0, oy = 0, oframe_start = 0
//  - ien=0, including mid-frame: same effect as reset on the next clock.
//    - Counters are forced to 0 and held; outputs go to inactive levels.
//    - No partial sync pulse is extended.
//  - ien 0->1 (or reset release with ien=1):
//    - The counters start at 0 on the first enabled clock.
//    - One clock later: ode=1, ox=0, oy=0, oframe_start=1.
//  - No other inputs; no overflow state exists. Counter width is the only constraint.
// TESTING
//  T1 reset: hold irst=0 for 5 clks with ien=1
//     -> ohsync=0, ovsync=0, ode=0, ox=oy=0, oframe_start=0 throughout.
//  T2 small raster: H 8/2/2/2, V 4/1/1/1, release reset with ien=1
//     -> oframe_start high on clock 1 with ode=1, ox=0, oy=0.
//     -> 32 de clocks per frame; frame period 14*7 = 98 clks.
//  T3 default params, run 2 frames
//     -> de count per frame = 2,073,600.
//     -> hsync high for 44 clks starting 2008 clks after each line's first de.
//     -> one vsync rising edge per 2,475,000 clks; vsync width 11,000 clks.
//  T4 ien low at mid-frame (small raster, v_cnt=2, h_cnt=5)
//     -> next clk: all outputs inactive.
//     -> ien high again: oframe_start one clock after re-enable; ox/oy restart at 0.
//  T5 polarity: H_POL=0, V_POL=0 -> idle levels are 1; pulses go low with the T2 timing.
//  T6 wrap: check at the last clock of the frame
//     -> x = H_ACTIVE-1 appears only on active lines.
//     -> the output following h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 is oframe_start=1, ox=0, oy=0.

Source files
------------

// File: rtl/panel_timing_gen.sv
// Raster timing generator: free-running H/V counters with registered sync, data-enable,
// pixel coordinates and frame-start pulse. One clock of latency from counters to outputs.
module panel_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   CNT_W    = 12
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ien,
  output logic             ohsync,
  output logic             ovsync,
  output logic             ode,
  output logic [CNT_W-1:0] ox,
  output logic [CNT_W-1:0] oy,
  output logic             oframe_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_fs;

  logic w_h_last;
  logic w_v_last;
  logic w_hs_act;
  logic w_vs_act;
  logic w_de;
  logic w_fs;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_hs_act = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  // vsync decodes only v_cnt, so both edges land on the output after h_cnt = 0
  assign w_vs_act = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign w_de     = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge iclk) begin
    if (!irst || !ien) begin
      // Disable behaves like reset: raster parked at origin, outputs idle
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_fs    <= 1'b0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
      r_hsync <= w_hs_act ? H_POL : ~H_POL;
      r_vsync <= w_vs_act ? V_POL : ~V_POL;
      r_de    <= w_de;
      r_x     <= w_de ? r_h_cnt : '0;
      r_y     <= w_de ? r_v_cnt : '0;
      r_fs    <= w_fs;
    end
  end

  assign ohsync       = r_hsync;
  assign ovsync       = r_vsync;
  assign ode          = r_de;
  assign ox           = r_x;
  assign oy           = r_y;
  assign oframe_start = r_fs;

endmodule

// File: tb/tb_panel_timing_gen.sv
// Bench for panel_timing_gen: small raster (both polarities) plus default 1080p raster,
// per-clock scoreboard on every output and hand-computed period/width measurements.
module tb_panel_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] x;
    logic [11:0] y;
  } out_t;

  logic clk = 1'b0;
  logic irst;
  logic ien;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_de, a_fs;
  logic b_hs, b_vs, b_de, b_fs;
  logic c_hs, c_vs, c_de, c_fs;
  logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;

  panel_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1), .CNT_W(12)) dut_a (
    .iclk(clk), .irst(irst), .ien(ien), .ohsync(a_hs), .ovsync(a_vs),
    .ode(a_de), .ox(a_x), .oy(a_y), .oframe_start(a_fs));

  panel_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1'b0), .V_POL(1'b0), .CNT_W(12)) dut_b (
    .iclk(clk), .irst(irst), .ien(ien), .ohsync(b_hs), .ovsync(b_vs),
    .ode(b_de), .ox(b_x), .oy(b_y), .oframe_start(b_fs));

  panel_timing_gen dut_c (
    .iclk(clk), .irst(irst), .ien(ien), .ohsync(c_hs), .ovsync(c_vs),
    .ode(c_de), .ox(c_x), .oy(c_y), .oframe_start(c_fs));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k = 0;
  int disrupt = 0;
  out_t qa[$];
  out_t qb[$];
  out_t qc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected output after an edge, from the number k of enabled clocks since origin
  function automatic out_t exp_out(input bit idle, input int kk,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
    out_t o;
    int ht, vt, h, v;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    o = '0;
    o.hs = ~hp;
    o.vs = ~vp;
    if (!idle) begin
      h = kk % ht;
      v = (kk / ht) % vt;
      o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
      o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
      o.de = (h < ha) && (v < va);
      o.fs = (h == 0) && (v == 0);
      o.x  = o.de ? 12'(h) : 12'd0;
      o.y  = o.de ? 12'(v) : 12'd0;
    end
    return o;
  endfunction

  task automatic step(input bit r, input bit e);
    bit idle;
    irst = r;
    ien  = e;
    idle = !r || !e;
    qa.push_back(exp_out(idle, k, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1));
    qb.push_back(exp_out(idle, k, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0));
    qc.push_back(exp_out(idle, k, 1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1));
    if (idle) begin
      k = 0;
      disrupt++;
    end else begin
      k++;
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops plus edge-timing measurements
  int a_fs_cyc, a_fs_dis = -1, a_de_cnt, a_vs_cyc, a_vs_dis = -1, a_hs_cyc, a_hs_dis = -1;
  int c_de_cyc, c_de_dis = -1, c_hs_cyc, c_hs_dis = -1;
  logic a_vs_p, a_hs_p, c_de_p, c_hs_p;
  bit a_fs_seen = 0;

  always @(negedge clk) begin
    cyc++;
    if (qa.size() > 0) chk("sb_small_pos", 64'({a_hs, a_vs, a_de, a_fs, a_x, a_y}), 64'(qa.pop_front()));
    if (qb.size() > 0) chk("sb_small_neg", 64'({b_hs, b_vs, b_de, b_fs, b_x, b_y}), 64'(qb.pop_front()));
    if (qc.size() > 0) chk("sb_default", 64'({c_hs, c_vs, c_de, c_fs, c_x, c_y}), 64'(qc.pop_front()));

    if (a_fs === 1'b1) begin
      if (a_fs_seen && a_fs_dis == disrupt) begin
        chk("frame_period", 64'(cyc - a_fs_cyc), 64'd98);
        chk("de_per_frame", 64'(a_de_cnt), 64'd32);
      end
      a_fs_seen = 1;
      a_fs_cyc  = cyc;
      a_fs_dis  = disrupt;
      a_de_cnt  = 0;
    end
    if (a_de === 1'b1) a_de_cnt++;
    if (a_vs === 1'b1 && a_vs_p === 1'b0) begin a_vs_cyc = cyc; a_vs_dis = disrupt; end
    if (a_vs === 1'b0 && a_vs_p === 1'b1 && a_vs_dis == disrupt)
      chk("vsync_width_small", 64'(cyc - a_vs_cyc), 64'd14);
    if (a_hs === 1'b1 && a_hs_p === 1'b0) begin a_hs_cyc = cyc; a_hs_dis = disrupt; end
    if (a_hs === 1'b0 && a_hs_p === 1'b1 && a_hs_dis == disrupt)
      chk("hsync_width_small", 64'(cyc - a_hs_cyc), 64'd2);

    if (c_de === 1'b1 && c_de_p === 1'b0) begin c_de_cyc = cyc; c_de_dis = disrupt; end
    if (c_de === 1'b0 && c_de_p === 1'b1 && c_de_dis == disrupt)
      chk("de_per_line", 64'(cyc - c_de_cyc), 64'd1920);
    if (c_hs === 1'b1 && c_hs_p === 1'b0) begin
      if (c_de_dis == disrupt) chk("hsync_offset", 64'(cyc - c_de_cyc), 64'd2008);
      c_hs_cyc = cyc;
      c_hs_dis = disrupt;
    end
    if (c_hs === 1'b0 && c_hs_p === 1'b1 && c_hs_dis == disrupt)
      chk("hsync_width", 64'(cyc - c_hs_cyc), 64'd44);

    a_vs_p = a_vs;
    a_hs_p = a_hs;
    c_de_p = c_de;
    c_hs_p = c_hs;
  end

  initial begin
    irst = 1'b0;
    ien  = 1'b1;
    // Reset held with enable high
    repeat (5) step(1'b0, 1'b1);
    // Three full small frames, then advance to v=2, h=5
    repeat (3 * 98 + 33) step(1'b1, 1'b1);
    // Mid-frame disable, then re-enable and run past two frames
    repeat (3) step(1'b1, 1'b0);
    repeat (200) step(1'b1, 1'b1);
    // Reset with enable low, then two-plus default-raster lines
    repeat (2) step(1'b0, 1'b0);
    repeat (4500) step(1'b1, 1'b1);
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_c", 64'(qc.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
